padding_3d_stream: RTL

- Parametrised successor to the fixed two-lane padding_3D_FFT front end.
- Accepts a streamed IN_N^3 complex cube and emits a zero-padded OUT_N^3 cube with LANES complex samples per beat, raster order x fastest, then y, then z.
- Adds valid/ready backpressure on both sides, frame start/last framing, and selectable pad placement (trailing or centred).
- Sits between the sample source and the first-dimension FFT stage.

---
 rtl/padding_pkg.sv | 21 ++
 rtl/pad_coord_counter.sv | 78 +++++++
 rtl/padding_3d_stream.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/padding_pkg.sv
// Shared encodings for the 3-D zero-padding stream front end.
package padding_pkg;

    // Pad placement, latched at frame start
    localparam logic PAD_TRAIL  = 1'b0;
    localparam logic PAD_CENTER = 1'b1;

    // Frame sequencer states
    typedef logic [1:0] state_t;
    localparam state_t StIdle  = 2'd0;
    localparam state_t StRun   = 2'd1;
    localparam state_t StDrain = 2'd2;

    // First in-region coordinate along every axis for the given placement
    function automatic int unsigned pad_offset(input int unsigned out_n,
                                               input int unsigned in_n,
                                               input logic        mode);
        return (mode == PAD_CENTER) ? (out_n - in_n) / 2 : 0;
    endfunction

endpackage

// File: rtl/pad_coord_counter.sv
// Output-cube raster position (x fastest, then y, then z) with end-of-frame
// flag and data-region test for the current beat.
module pad_coord_counter
    import padding_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned IN_N  = 4,
    parameter int unsigned OUT_N = 8,
    parameter int unsigned CW    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        step,
    input  logic [CW:0] off,
    output logic        last_beat,
    output logic        in_region
);

    // One extra bit so OUT_N and off+IN_N are representable
    typedef logic [CW:0] ext_t;

    localparam ext_t XLast = ext_t'(OUT_N - LANES);
    localparam ext_t NLast = ext_t'(OUT_N - 1);
    localparam ext_t Step  = ext_t'(LANES);
    localparam ext_t Span  = ext_t'(IN_N);

    logic [CW-1:0] x_q, y_q, z_q;
    logic [CW-1:0] x_d, y_d, z_d;
    logic          x_wrap, y_wrap, z_wrap;

    // Coordinate lies inside [o, o+IN_N)
    function automatic logic in_span(input logic [CW-1:0] c, input ext_t o);
        return ({1'b0, c} >= o) && ({1'b0, c} < (o + Span));
    endfunction

    // Wrap flags and region / last-beat decode
    always_comb begin
        x_wrap    = ({1'b0, x_q} == XLast);
        y_wrap    = ({1'b0, y_q} == NLast);
        z_wrap    = ({1'b0, z_q} == NLast);
        last_beat = x_wrap && y_wrap && z_wrap;
        in_region = in_span(x_q, off) && in_span(y_q, off) && in_span(z_q, off);
    end

    // Next position: x steps by LANES, carries ripple into y then z
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        if (step) begin
            if (x_wrap) begin
                x_d = '0;
                if (y_wrap) begin
                    y_d = '0;
                    z_d = z_wrap ? '0 : z_q + 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + Step[CW-1:0];
            end
        end
    end

    // Position registers, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
        end
    end

endmodule

// File: rtl/padding_3d_stream.sv
// Streams an IN_N^3 complex cube in and emits it zero-padded to OUT_N^3,
// LANES samples per beat, with valid/ready on both sides and frame framing.
module padding_3d_stream
    import padding_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned LANES = 2,
    parameter int unsigned IN_N  = 4,
    parameter int unsigned OUT_N = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_in_en,
    input  logic                  io_start,
    input  logic                  io_mode,
    input  logic                  io_in_valid,
    output logic                  io_in_ready,
    input  logic [LANES*DW-1:0]   io_in_data_re,
    input  logic [LANES*DW-1:0]   io_in_data_im,
    output logic                  io_out_valid,
    input  logic                  io_out_ready,
    output logic [LANES*DW-1:0]   io_out_data_re,
    output logic [LANES*DW-1:0]   io_out_data_im,
    output logic                  io_out_last,
    output logic                  io_busy
);

    localparam int unsigned CW = $clog2(OUT_N);

    typedef logic [CW:0] ext_t;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } sample_t;

    state_t               state_q, state_d;
    logic                 mode_q, mode_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    sample_t [LANES-1:0]  out_q, out_d;
    sample_t [LANES-1:0]  in_s;

    ext_t                 off;
    logic                 last_beat;
    logic                 in_region;
    logic                 can_load;
    logic                 load;
    logic                 accept;

    assign off = ext_t'(pad_offset(OUT_N, IN_N, mode_q));

    pad_coord_counter #(
        .LANES (LANES),
        .IN_N  (IN_N),
        .OUT_N (OUT_N),
        .CW    (CW)
    ) u_coord (
        .clock     (clock),
        .reset     (reset),
        .step      (load),
        .off       (off),
        .last_beat (last_beat),
        .in_region (in_region)
    );

    // Handshake decode: a beat loads only when the output slot is free or emptying
    always_comb begin
        can_load    = (state_q == StRun) && io_in_en && (!out_valid_q || io_out_ready);
        load        = can_load && (!in_region || io_in_valid);
        accept      = out_valid_q && io_out_ready;
        io_in_ready = can_load && in_region;
    end

    // Unpack input lanes into samples
    always_comb begin
        in_s = '0;
        for (int k = 0; k < LANES; k++) begin
            in_s[k].re = io_in_data_re[k*DW +: DW];
            in_s[k].im = io_in_data_im[k*DW +: DW];
        end
    end

    // Output register and frame sequencer next state
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_d       = out_q;

        if (load) begin
            out_valid_d = 1'b1;
            out_last_d  = last_beat;
            out_d       = in_region ? in_s : '0;
        end else if (accept) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (io_start && io_in_en) begin
                    state_d = StRun;
                    mode_d  = io_mode;
                end
            end
            StRun: begin
                if (load && last_beat) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // The final beat may already have been taken while enable was low
                if (io_in_en && (accept || !out_valid_q)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            mode_q      <= PAD_TRAIL;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_q       <= out_d;
        end
    end

    // Pack output samples back onto the lane buses
    always_comb begin
        io_out_data_re = '0;
        io_out_data_im = '0;
        for (int k = 0; k < LANES; k++) begin
            io_out_data_re[k*DW +: DW] = out_q[k].re;
            io_out_data_im[k*DW +: DW] = out_q[k].im;
        end
    end

    assign io_out_valid = out_valid_q;
    assign io_out_last  = out_last_q;
    assign io_busy      = (state_q == StRun) || (state_q == StDrain);

endmodule
